// File: rtl/vid_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// vid_ctrl_pkg
// Shared definitions for the pixel-filter mode controller: filter mode
// encodings, button index assignments and the wrap-around mode stepping
// helper used by the press decoder.
// -----------------------------------------------------------------------------
package vid_ctrl_pkg;

  localparam int MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  // Filter mux select encodings
  localparam mode_t MODE_PASS   = 2'd0;
  localparam mode_t MODE_GRAY   = 2'd1;
  localparam mode_t MODE_INV    = 2'd2;
  localparam mode_t MODE_THRESH = 2'd3;

  // Board button positions in the btn bus
  localparam int BTN_NEXT = 0;
  localparam int BTN_PREV = 1;
  localparam int BTN_INV  = 2;
  localparam int BTN_CLR  = 3;

  // Step a mode up or down by one; 2-bit arithmetic gives the 3<->0 wrap.
  function automatic mode_t mode_step(input mode_t m, input logic up);
    mode_t r;
    if (up) begin
      r = m + 2'd1;
    end else begin
      r = m - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One push button: 2-flop synchroniser, stability counter, debounced level
// and a one-cycle press pulse on each accepted rising edge.
//
// Ports:
//   clk      in   clock
//   n_rst    in   asynchronous active-low reset
//   btn_raw  in   raw asynchronous button level, active-high
//   o_press  out  registered one-cycle pulse when the debounced level rises
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic n_rst,
  input  logic btn_raw,
  output logic o_press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             db_q;
  logic             db_d;
  logic             press_q;
  logic             press_d;

  // Next-state for the stability counter, debounced level and press pulse
  always_comb begin
    cnt_d   = cnt_q;
    db_d    = db_q;
    press_d = 1'b0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_MAX) begin
        // Level held long enough: accept it and restart counting.
        db_d    = sync2_q;
        cnt_d   = {CNT_W{1'b0}};
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      // Any return to the accepted level discards the partial count.
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Synchroniser and debounce state registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      db_q    <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      press_q <= press_d;
    end
  end

  assign o_press = press_q;

endmodule

// File: rtl/filter_mode_ctrl.sv
// -----------------------------------------------------------------------------
// filter_mode_ctrl
// Turns debounced button presses into a pending filter mode and commits it
// to the active mode only at a vsync rising edge so the filter mux never
// switches mid-frame.
//
// Ports:
//   clk          in   pixel clock
//   n_rst        in   asynchronous active-low reset
//   btn[3:0]     in   raw push buttons (0 next, 1 prev, 2 invert, 3 clear)
//   i_vid_vsync  in   vertical sync, active-high, asynchronous
//   i_vid_VDE    in   video data enable
//   o_mode       out  active filter mode (mux select)
//   o_pending    out  mode to be committed at the next vsync
//   o_switch     out  one-cycle pulse when o_mode changes
//   o_frame_cnt  out  wrapping count of vsync rising edges
//   o_in_frame   out  registered i_vid_VDE
// -----------------------------------------------------------------------------
module filter_mode_ctrl
  import vid_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FRAME_CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [3:0]             btn,
  input  logic                   i_vid_vsync,
  input  logic                   i_vid_VDE,
  output logic [MODE_W-1:0]      o_mode,
  output logic [MODE_W-1:0]      o_pending,
  output logic                   o_switch,
  output logic [FRAME_CNT_W-1:0] o_frame_cnt,
  output logic                   o_in_frame
);

  logic [3:0]             press_s;

  logic                   vs_sync1_q;
  logic                   vs_sync2_q;
  logic                   vs_prev_q;
  logic                   vs_rise_q;

  mode_t                  pending_q;
  mode_t                  pending_d;
  mode_t                  mode_q;
  mode_t                  mode_d;
  logic                   switch_q;
  logic                   switch_d;
  logic [FRAME_CNT_W-1:0] frame_q;
  logic [FRAME_CNT_W-1:0] frame_d;
  logic                   in_frame_q;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clk     (clk),
      .n_rst   (n_rst),
      .btn_raw (btn[i]),
      .o_press (press_s[i])
    );
  end

  // Priority press decode: clear > invert > next > prev, one action per cycle
  always_comb begin
    pending_d = pending_q;
    if (press_s[BTN_CLR]) begin
      pending_d = MODE_PASS;
    end else if (press_s[BTN_INV]) begin
      pending_d = MODE_INV;
    end else if (press_s[BTN_NEXT]) begin
      pending_d = mode_step(pending_q, 1'b1);
    end else if (press_s[BTN_PREV]) begin
      pending_d = mode_step(pending_q, 1'b0);
    end else begin
      pending_d = pending_q;
    end
  end

  // Commit at vsync rise; a press landing in the same cycle is seen next frame
  always_comb begin
    mode_d   = mode_q;
    switch_d = 1'b0;
    frame_d  = frame_q;
    if (vs_rise_q) begin
      frame_d = frame_q + FRAME_CNT_W'(1);
      if (pending_q != mode_q) begin
        mode_d   = pending_q;
        switch_d = 1'b1;
      end else begin
        mode_d   = mode_q;
        switch_d = 1'b0;
      end
    end else begin
      frame_d = frame_q;
    end
  end

  // Vsync synchroniser, registered rise detect and mode/frame state
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vs_sync1_q <= 1'b0;
      vs_sync2_q <= 1'b0;
      vs_prev_q  <= 1'b0;
      vs_rise_q  <= 1'b0;
      pending_q  <= MODE_PASS;
      mode_q     <= MODE_PASS;
      switch_q   <= 1'b0;
      frame_q    <= {FRAME_CNT_W{1'b0}};
      in_frame_q <= 1'b0;
    end else begin
      vs_sync1_q <= i_vid_vsync;
      vs_sync2_q <= vs_sync1_q;
      vs_prev_q  <= vs_sync2_q;
      vs_rise_q  <= vs_sync2_q & ~vs_prev_q;
      pending_q  <= pending_d;
      mode_q     <= mode_d;
      switch_q   <= switch_d;
      frame_q    <= frame_d;
      in_frame_q <= i_vid_VDE;
    end
  end

  assign o_mode      = mode_q;
  assign o_pending   = pending_q;
  assign o_switch    = switch_q;
  assign o_frame_cnt = frame_q;
  assign o_in_frame  = in_frame_q;

endmodule

// File: tb/tb_filter_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_filter_mode_ctrl
// Directed bench for filter_mode_ctrl with an 8-cycle debounce window.
// Inputs change 1 time unit after a rising edge; outputs are read at the
// same point, so a button set after edge E gives o_pending at E+11 and a
// vsync set after edge E commits at E+4.
// -----------------------------------------------------------------------------
module tb_filter_mode_ctrl;

  localparam int DC = 8;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [3:0]    btn;
  logic          vsync;
  logic          vde;
  logic [1:0]    o_mode;
  logic [1:0]    o_pending;
  logic          o_switch;
  logic [FW-1:0] o_frame_cnt;
  logic          o_in_frame;

  int n_checks = 0;
  int n_fail   = 0;

  filter_mode_ctrl #(
    .DEBOUNCE_CYCLES (DC),
    .FRAME_CNT_W     (FW)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .btn         (btn),
    .i_vid_vsync (vsync),
    .i_vid_VDE   (vde),
    .o_mode      (o_mode),
    .o_pending   (o_pending),
    .o_switch    (o_switch),
    .o_frame_cnt (o_frame_cnt),
    .o_in_frame  (o_in_frame)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold a button mask long enough for one press, then release and settle
  task automatic press(input logic [3:0] mask);
    btn = mask;
    step(20);
    btn = 4'b0000;
    step(15);
  endtask

  task automatic do_vsync();
    vsync = 1'b1;
    step(2);
    vsync = 1'b0;
    step(6);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    vde   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      btn   = 4'(i * 5);
      vsync = i[0];
      step(1);
    end
    n_checks++; if (o_mode !== 2'd0) begin n_fail++; $display("FAIL rst_mode: got %0d expected 0", o_mode); end
    n_checks++; if (o_pending !== 2'd0) begin n_fail++; $display("FAIL rst_pending: got %0d expected 0", o_pending); end
    n_checks++; if (o_switch !== 1'b0) begin n_fail++; $display("FAIL rst_switch: got %0b expected 0", o_switch); end
    n_checks++; if (o_frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_frame: got %0d expected 0", o_frame_cnt); end
    n_checks++; if (o_in_frame !== 1'b0) begin n_fail++; $display("FAIL rst_in_frame: got %0b expected 0", o_in_frame); end
    btn   = 4'b0000;
    vsync = 1'b0;
    vde   = 1'b0;
    step(1);
    n_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      n_checks++;
      if (o_switch !== 1'b0 || o_mode !== 2'd0 || o_pending !== 2'd0) begin
        n_fail++;
        $display("FAIL idle_after_rst: got switch=%0b mode=%0d pending=%0d expected 0/0/0", o_switch, o_mode, o_pending);
      end
    end
    n_checks++; if (o_frame_cnt !== 16'd0) begin n_fail++; $display("FAIL idle_frame: got %0d expected 0", o_frame_cnt); end
  endtask

  task automatic test_in_frame();
    vde = 1'b1;
    n_checks++; if (o_in_frame !== 1'b0) begin n_fail++; $display("FAIL in_frame_comb: got %0b expected 0", o_in_frame); end
    step(1);
    n_checks++; if (o_in_frame !== 1'b1) begin n_fail++; $display("FAIL in_frame_set: got %0b expected 1", o_in_frame); end
    vde = 1'b0;
    step(1);
    n_checks++; if (o_in_frame !== 1'b0) begin n_fail++; $display("FAIL in_frame_clr: got %0b expected 0", o_in_frame); end
  endtask

  task automatic test_next_commit();
    btn = 4'b0001;
    step(10);
    n_checks++; if (o_pending !== 2'd0) begin n_fail++; $display("FAIL next_early: got %0d expected 0", o_pending); end
    step(1);
    n_checks++; if (o_pending !== 2'd1) begin n_fail++; $display("FAIL next_latency: got %0d expected 1", o_pending); end
    step(9);
    btn = 4'b0000;
    step(15);
    n_checks++; if (o_pending !== 2'd1) begin n_fail++; $display("FAIL held_once: got %0d expected 1", o_pending); end
    n_checks++; if (o_mode !== 2'd0) begin n_fail++; $display("FAIL mode_before_vsync: got %0d expected 0", o_mode); end
    vsync = 1'b1;
    step(2);
    vsync = 1'b0;
    step(1);
    n_checks++; if (o_mode !== 2'd0 || o_switch !== 1'b0) begin n_fail++; $display("FAIL commit_early: got mode=%0d switch=%0b expected 0/0", o_mode, o_switch); end
    step(1);
    n_checks++; if (o_mode !== 2'd1) begin n_fail++; $display("FAIL commit_mode: got %0d expected 1", o_mode); end
    n_checks++; if (o_switch !== 1'b1) begin n_fail++; $display("FAIL commit_switch: got %0b expected 1", o_switch); end
    n_checks++; if (o_frame_cnt !== 16'd1) begin n_fail++; $display("FAIL commit_frame: got %0d expected 1", o_frame_cnt); end
    step(1);
    n_checks++; if (o_switch !== 1'b0 || o_mode !== 2'd1) begin n_fail++; $display("FAIL switch_one_cycle: got switch=%0b mode=%0d expected 0/1", o_switch, o_mode); end
  endtask

  task automatic test_prev_wrap();
    press(4'b1000);
    n_checks++; if (o_pending !== 2'd0) begin n_fail++; $display("FAIL clr: got %0d expected 0", o_pending); end
    press(4'b0010);
    n_checks++; if (o_pending !== 2'd3) begin n_fail++; $display("FAIL prev_wrap: got %0d expected 3", o_pending); end
    press(4'b0001);
    n_checks++; if (o_pending !== 2'd0) begin n_fail++; $display("FAIL next_wrap: got %0d expected 0", o_pending); end
    press(4'b0010);
    n_checks++; if (o_pending !== 2'd3) begin n_fail++; $display("FAIL prev_wrap2: got %0d expected 3", o_pending); end
    for (int i = 0; i < 4; i++) begin
      btn = 4'b0001;
      step(5);
      btn = 4'b0000;
      step(3);
    end
    step(15);
    n_checks++; if (o_pending !== 2'd3) begin n_fail++; $display("FAIL bounce: got %0d expected 3", o_pending); end
  endtask

  task automatic test_coincident();
    press(4'b0101);
    n_checks++; if (o_pending !== 2'd2) begin n_fail++; $display("FAIL inv_over_next: got %0d expected 2", o_pending); end
    press(4'b1010);
    n_checks++; if (o_pending !== 2'd0) begin n_fail++; $display("FAIL clr_over_prev: got %0d expected 0", o_pending); end
  endtask

  task automatic test_vsync_aligned();
    do_vsync();
    n_checks++; if (o_mode !== 2'd0 || o_frame_cnt !== 16'd2) begin n_fail++; $display("FAIL pre_align: got mode=%0d frame=%0d expected 0/2", o_mode, o_frame_cnt); end
    btn = 4'b0001;
    step(7);
    vsync = 1'b1;
    step(2);
    vsync = 1'b0;
    step(2);
    n_checks++; if (o_mode !== 2'd0 || o_switch !== 1'b0) begin n_fail++; $display("FAIL align_no_commit: got mode=%0d switch=%0b expected 0/0", o_mode, o_switch); end
    n_checks++; if (o_pending !== 2'd1) begin n_fail++; $display("FAIL align_pending: got %0d expected 1", o_pending); end
    n_checks++; if (o_frame_cnt !== 16'd3) begin n_fail++; $display("FAIL align_frame: got %0d expected 3", o_frame_cnt); end
    step(1);
    n_checks++; if (o_switch !== 1'b0) begin n_fail++; $display("FAIL align_late_switch: got %0b expected 0", o_switch); end
    step(9);
    btn = 4'b0000;
    step(15);
    vsync = 1'b1;
    step(2);
    vsync = 1'b0;
    step(2);
    n_checks++; if (o_mode !== 2'd1 || o_switch !== 1'b1) begin n_fail++; $display("FAIL align_next_commit: got mode=%0d switch=%0b expected 1/1", o_mode, o_switch); end
    n_checks++; if (o_frame_cnt !== 16'd4) begin n_fail++; $display("FAIL align_next_frame: got %0d expected 4", o_frame_cnt); end
    step(1);
    n_checks++; if (o_switch !== 1'b0) begin n_fail++; $display("FAIL align_switch_width: got %0b expected 0", o_switch); end
  endtask

  task automatic test_reset_mid();
    press(4'b0100);
    press(4'b0001);
    n_checks++; if (o_pending !== 2'd3) begin n_fail++; $display("FAIL pend3: got %0d expected 3", o_pending); end
    do_vsync();
    n_checks++; if (o_mode !== 2'd3 || o_frame_cnt !== 16'd5) begin n_fail++; $display("FAIL mode3: got mode=%0d frame=%0d expected 3/5", o_mode, o_frame_cnt); end
    vde = 1'b1;
    btn = 4'b0001;
    step(6);
    n_rst = 1'b0;
    #2;
    n_checks++;
    if (o_mode !== 2'd0 || o_pending !== 2'd0 || o_switch !== 1'b0 || o_frame_cnt !== 16'd0 || o_in_frame !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: got mode=%0d pending=%0d switch=%0b frame=%0d in_frame=%0b expected all 0",
               o_mode, o_pending, o_switch, o_frame_cnt, o_in_frame);
    end
    btn = 4'b0000;
    vde = 1'b0;
    step(2);
    n_rst = 1'b1;
    step(20);
    n_checks++; if (o_pending !== 2'd0 || o_mode !== 2'd0) begin n_fail++; $display("FAIL partial_discard: got pending=%0d mode=%0d expected 0/0", o_pending, o_mode); end
    vsync = 1'b1;
    step(2);
    vsync = 1'b0;
    step(2);
    n_checks++; if (o_mode !== 2'd0 || o_switch !== 1'b0) begin n_fail++; $display("FAIL post_rst_vsync: got mode=%0d switch=%0b expected 0/0", o_mode, o_switch); end
    n_checks++; if (o_frame_cnt !== 16'd1) begin n_fail++; $display("FAIL post_rst_frame: got %0d expected 1", o_frame_cnt); end
    step(1);
    n_checks++; if (o_switch !== 1'b0) begin n_fail++; $display("FAIL post_rst_switch: got %0b expected 0", o_switch); end
  endtask

  initial begin
    n_rst = 1'b0;
    btn   = 4'b0000;
    vsync = 1'b0;
    vde   = 1'b0;
    step(2);
    test_reset();
    test_in_frame();
    test_next_commit();
    test_prev_wrap();
    test_coincident();
    test_vsync_aligned();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test expected finish within 1000000 time units");
    $fatal(1, "simulation time limit");
  end

endmodule
